// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - N-and-a-half digit BCD count chain with output latch and digit-strobe scan
// Optional leading-zero blank output enabled by BCD_SCAN_BLANK_EN.
module bcd_scan_counter #(
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cnt_en,
  input  logic                  clr,
  input  logic                  latch,
  output logic [4*DIGITS-1:0]   count_l,
  output logic                  half_l,
  output logic                  ovr,
  output logic [DIGITS:0]       ds,
  output logic [3:0]            bcd_q
`ifdef BCD_SCAN_BLANK_EN
  ,
  output logic                  blank
`endif
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);

  logic [4*DIGITS-1:0] chain;
  logic [4*DIGITS-1:0] chain_inc;
  logic                half;
  logic                half_inc;
  logic                full;

  logic [DW-1:0]       div;
  logic                wrap;
  logic [DIGITS:0]     ds_nxt;
  logic [3:0]          bcd_nxt;

  // Carry ripples through every decade in one cycle; full scale is 1 followed by all nines.
  always_comb begin
    logic       c;
    logic [3:0] nib;
    chain_inc = chain;
    full      = half;
    c         = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      nib  = chain[4*i +: 4];
      full = full & (nib == 4'd9);
      if (c) begin
        if (nib == 4'd9) begin
          chain_inc[4*i +: 4] = 4'd0;
        end else begin
          chain_inc[4*i +: 4] = nib + 4'd1;
          c = 1'b0;
        end
      end
    end
    half_inc = half | c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      half  <= 1'b0;
      ovr   <= 1'b0;
    end else if (clr) begin
      chain <= '0;
      half  <= 1'b0;
      ovr   <= 1'b0;
    end else if (cnt_en) begin
      if (full) begin
        ovr <= 1'b1;
      end else begin
        chain <= chain_inc;
        half  <= half_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_l <= '0;
      half_l  <= 1'b0;
    end else if (latch) begin
      count_l <= chain;
      half_l  <= half;
    end
  end

  assign wrap   = (div == DIV_MAX);
  assign ds_nxt = wrap ? {ds[0], ds[DIGITS:1]} : ds;

  always_comb begin
    bcd_nxt = 4'd0;
    if (ds_nxt[DIGITS]) begin
      bcd_nxt = {ovr, 2'b00, half_l};
    end
    for (int i = 0; i < DIGITS; i++) begin
      if (ds_nxt[i]) begin
        bcd_nxt = count_l[4*i +: 4];
      end
    end
  end

  // bcd_q is refreshed every cycle so a mid-slot latch shows up without restarting the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      ds    <= {1'b1, {DIGITS{1'b0}}};
      bcd_q <= 4'd0;
    end else begin
      div   <= wrap ? '0 : div + 1'b1;
      ds    <= ds_nxt;
      bcd_q <= bcd_nxt;
    end
  end

`ifdef BCD_SCAN_BLANK_EN
  logic blank_nxt;

  always_comb begin
    logic z;
    z         = ~half_l;
    blank_nxt = ds_nxt[DIGITS] & z;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z & (count_l[4*i +: 4] == 4'd0);
      if (ds_nxt[i]) begin
        blank_nxt = z;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank <= 1'b1;
    end else begin
      blank <= blank_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - randomized and directed bench for bcd_scan_counter
// Checks blank as well when built with BCD_SCAN_BLANK_EN.
module tb_bcd_scan_counter;

  localparam int D  = 3;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_en = 1'b0;
  logic        clr = 1'b0;
  logic        latch = 1'b0;
  logic [11:0] count_l;
  logic        half_l;
  logic        ovr;
  logic [3:0]  ds;
  logic [3:0]  bcd_q;
`ifdef BCD_SCAN_BLANK_EN
  logic        blank;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  bcd_scan_counter #(.DIGITS(D), .SCAN_DIV(SD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cnt_en  (cnt_en),
    .clr     (clr),
    .latch   (latch),
    .count_l (count_l),
    .half_l  (half_l),
    .ovr     (ovr),
    .ds      (ds),
    .bcd_q   (bcd_q)
`ifdef BCD_SCAN_BLANK_EN
    ,
    .blank   (blank)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int p10(input int p);
    int r = 1;
    for (int i = 0; i < p; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  // Digit position (D = half digit, 0 = LSD) shown after n edges since reset release.
  function automatic int pos_after(input int n);
    return D - ((n / SD) % (D + 1));
  endfunction

  function automatic logic [3:0] digit_of(input int p, input int v, input bit ov);
    if (p == D) return {ov, 2'b00, (v >= p10(D))};
    return 4'((v / p10(p)) % 10);
  endfunction

  // Reference model: counts as plain integers.
  int         m_cnt, m_cl, m_n;
  bit         m_ovr;
  logic [3:0] exp_ds, exp_bcd;
  bit         exp_blank;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt     <= 0;
      m_cl      <= 0;
      m_ovr     <= 1'b0;
      m_n       <= 0;
      exp_ds    <= 4'b1000;
      exp_bcd   <= 4'd0;
      exp_blank <= 1'b1;
    end else begin
      m_n       <= m_n + 1;
      exp_ds    <= 4'(1 << pos_after(m_n + 1));
      exp_bcd   <= digit_of(pos_after(m_n + 1), m_cl, m_ovr);
      exp_blank <= (pos_after(m_n + 1) > 0) && ((m_cl / p10(pos_after(m_n + 1))) == 0);
      if (clr) begin
        m_cnt <= 0;
        m_ovr <= 1'b0;
      end else if (cnt_en) begin
        if (m_cnt == 2 * p10(D) - 1) m_ovr <= 1'b1;
        else m_cnt <= m_cnt + 1;
      end
      if (latch) m_cl <= m_cnt;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("count_l", 32'(count_l), 32'(to_bcd(m_cl)));
      check("half_l", 32'(half_l), 32'(m_cl >= p10(D)));
      check("ovr", 32'(ovr), 32'(m_ovr));
      check("ds", 32'(ds), 32'(exp_ds));
      check("bcd_q", 32'(bcd_q), 32'(exp_bcd));
`ifdef BCD_SCAN_BLANK_EN
      check("blank", 32'(blank), 32'(exp_blank));
`endif
    end
  end

  task automatic cyc(input bit ce, input bit cl, input bit la);
    @(negedge clk);
    cnt_en = ce;
    clr    = cl;
    latch  = la;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
  endtask

  task automatic latch_and_check(input string tag, input logic [11:0] cl, input bit h);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check({tag, "_count"}, 32'(count_l), 32'(cl));
    check({tag, "_half"}, 32'(half_l), 32'(h));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ds", 32'(ds), 32'h8);
    check("rst_bcd", 32'(bcd_q), 32'h0);
`ifdef BCD_SCAN_BLANK_EN
    check("rst_blank", 32'(blank), 32'h1);
`endif
    rst_n = 1'b1;

    pulses(1234);
    latch_and_check("n1234", 12'h234, 1'b1);
    repeat (24) cyc(1'b0, 1'b0, 1'b0);

    cyc(1'b0, 1'b1, 1'b0);
    pulses(999);
    latch_and_check("c999", 12'h999, 1'b0);
    pulses(1);
    latch_and_check("c1000", 12'h000, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    pulses(10);
    latch_and_check("c0010", 12'h010, 1'b0);

    cyc(1'b0, 1'b1, 1'b0);
    pulses(2005);
    cyc(1'b0, 1'b0, 1'b0);
    check("sat_ovr", 32'(ovr), 32'h1);
    latch_and_check("sat", 12'h999, 1'b1);
    repeat (20) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("clr_ovr", 32'(ovr), 32'h0);

    pulses(5);
    cyc(1'b1, 1'b1, 1'b0);
    latch_and_check("clr_ce", 12'h000, 1'b0);
    pulses(567);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("la_clr_count", 32'(count_l), 32'h567);
    latch_and_check("la_clr_chain", 12'h000, 1'b0);
    pulses(41);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    check("la_ce_count", 32'(count_l), 32'h041);
    latch_and_check("la_ce_chain", 12'h042, 1'b0);

    cyc(1'b0, 1'b1, 1'b0);
    pulses(7);
    latch_and_check("seven", 12'h007, 1'b0);
    repeat (20) cyc(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 499) == 0), ($urandom_range(0, 7) == 0));
    end
    cyc(1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a slot.
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_ds", 32'(ds), 32'h8);
    check("arst_bcd", 32'(bcd_q), 32'h0);
    check("arst_count", 32'(count_l), 32'h0);
    check("arst_half", 32'(half_l), 32'h0);
    check("arst_ovr", 32'(ovr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("first_slot_hold", 32'(ds), 32'h8);
    @(posedge clk);
    #1 check("first_slot_end", 32'(ds), 32'h4);
    repeat (10) cyc(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
